saes64_issue_ctrl: RTL
======================

SAES64_ISSUE_CTRL -- requirements
Module: saes64_issue_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16: cycles fu_valid may wait for fu_ready before abort (used only with SAES64_ISSUE_TIMEOUT_EN).
REQ-002 The block SHALL have port g_clk, input, 1: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port g_resetn, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1: command offered.
REQ-005 The block SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-006 The block SHALL have port cmd_op, input, 3: 0 ks1, 1 ks2, 2 imix, 3 encs, 4 encsm, 5 decs, 6 decsm, 7 illegal.
REQ-007 The block SHALL have ports cmd_rs1 and cmd_rs2, input, 64 each: source operands.
REQ-008 The block SHALL have ports cmd_rcon, input, 4 (ks1 round constant), and cmd_tag, input, 4 (returned with the response).
REQ-009 The block SHALL have port fu_valid, output, 1: request to the SAES64 functional unit.
REQ-010 The block SHALL have ports fu_rs1 and fu_rs2, output, 64 each, and fu_enc_rcon, output, 4: registered operands.
REQ-011 The block SHALL have ports fu_op_saes64_ks1, ks2, imix, encs, encsm, decs and decsm, output, 1 each: one-hot op select.
REQ-012 The block SHALL have ports fu_ready, input, 1 (FU result valid), and fu_rd, input, 64 (FU result).
REQ-013 The block SHALL have ports rsp_valid, output, 1, and rsp_ready, input, 1: response handshake.
REQ-014 The block SHALL have ports rsp_rd, output, 64; rsp_tag, output, 4; rsp_err, output, 1: response payload.
REQ-015 The block SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, RESP; cmd_ready SHALL be high only in IDLE.
REQ-017 On a legal command accept in cycle N, operands, tag and one-hot op SHALL be registered, and fu_valid SHALL be high from cycle N+1 (state ISSUE).
REQ-018 In ISSUE, fu_valid and all fu_* operand/op outputs SHALL stay stable until fu_ready is sampled high.
REQ-019 In the cycle fu_ready is high in ISSUE, fu_rd SHALL be captured into rsp_rd, rsp_err cleared, and state SHALL move to RESP; fu_valid SHALL be low the next cycle.
REQ-020 Minimum latency SHALL be 2 cycles from cmd accept to rsp_valid, reached when fu_ready is high in the first ISSUE cycle.
REQ-021 fu_ready while not in ISSUE SHALL be ignored.
REQ-022 cmd_op=7 SHALL NOT assert fu_valid; state SHALL go IDLE->RESP with rsp_rd=0, rsp_err=1, rsp_tag=cmd_tag.
REQ-023 In RESP, rsp_valid SHALL be high and the payload SHALL be stable until rsp_ready is high; then state SHALL return to IDLE, and the next command SHALL be accepted no earlier than the following cycle.
REQ-024 All fu_op_* outputs SHALL be zero whenever fu_valid is low.

Reset
REQ-025 Asserting g_resetn low SHALL immediately force IDLE, cmd_ready=1 (once released), fu_valid=0, all fu_op_*=0, rsp_valid=0, rsp_err=0, busy=0, and fu_rs1, fu_rs2, fu_enc_rcon, rsp_rd and rsp_tag to 0.
REQ-026 Reset during ISSUE or RESP SHALL abandon the transaction without producing a response.

Configuration
REQ-027 With SAES64_ISSUE_TIMEOUT_EN defined, a counter SHALL count ISSUE cycles; if TIMEOUT_CYCLES cycles elapse without fu_ready, fu_valid SHALL drop and state SHALL go to RESP with rsp_rd=0 and rsp_err=1.
REQ-028 The timeout counter SHALL clear on entry to ISSUE; fu_ready in the final counted cycle SHALL take priority over timeout.
REQ-029 Without SAES64_ISSUE_TIMEOUT_EN, ISSUE SHALL wait indefinitely, no counter SHALL exist, and rsp_err SHALL be set only for illegal ops.

Verification
REQ-030 ks1, rs1=64'h0123456789ABCDEF, rcon=4'h3, tag=5, fu_ready same cycle as fu_valid, fu_rd=64'hDEAD -> fu_op_saes64_ks1 only; rsp_valid at accept+2; rsp_rd=64'hDEAD, tag=5, err=0.
REQ-031 encsm, fu_ready delayed 5 cycles -> fu_valid and operands stable for 6 cycles; one response.
REQ-032 cmd_op=7, tag=9 -> fu_valid never high; rsp_err=1, rsp_rd=0, rsp_tag=9.
REQ-033 rsp_ready held low 4 cycles -> rsp_valid and payload stable; cmd_ready low until the cycle after rsp_ready.
REQ-034 With macro, TIMEOUT_CYCLES=4, no fu_ready -> fu_valid drops after 4 cycles; rsp_err=1. Without macro -> fu_valid held for 100 cycles.
REQ-035 g_resetn pulsed low mid-ISSUE -> fu_valid=0 and rsp_valid=0 asynchronously; no response; cmd_ready=1 after release.

Source files
------------

// File: rtl/saes64_issue_ctrl.sv
// -----------------------------------------------------------------------------
// saes64_issue_ctrl
//   Issue/response sequencer sitting between a command port and the SAES64
//   functional unit. A command is accepted in IDLE, its operands and one-hot
//   op select are registered and presented to the FU in ISSUE until the FU
//   signals completion, and the result is held in RESP until the consumer
//   takes it. Illegal ops (cmd_op == 7) never reach the FU; they go straight
//   to RESP with an error response.
//
//   Optional feature (macro SAES64_ISSUE_TIMEOUT_EN):
//     ISSUE aborts after TIMEOUT_CYCLES cycles without fu_ready and returns an
//     error response. Without the macro ISSUE waits indefinitely and no
//     timeout counter is built.
//
// Parameters
//   TIMEOUT_CYCLES : ISSUE cycles allowed before abort (timeout build only)
//
// Ports
//   g_clk, g_resetn            : clock, async active-low reset
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_op, cmd_rs1, cmd_rs2,
//   cmd_rcon, cmd_tag          : command payload
//   fu_valid                   : request to the FU (high for the whole ISSUE)
//   fu_rs1, fu_rs2, fu_enc_rcon: registered operands
//   fu_op_saes64_*             : one-hot op select, zero whenever fu_valid low
//   fu_ready, fu_rd            : FU result valid / result
//   rsp_valid/rsp_ready        : response handshake
//   rsp_rd, rsp_tag, rsp_err   : response payload
//   busy                       : high whenever not IDLE
// -----------------------------------------------------------------------------
module saes64_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  // command
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_rs1,
  input  logic [63:0] cmd_rs2,
  input  logic [3:0]  cmd_rcon,
  input  logic [3:0]  cmd_tag,
  // functional unit
  output logic        fu_valid,
  output logic [63:0] fu_rs1,
  output logic [63:0] fu_rs2,
  output logic [3:0]  fu_enc_rcon,
  output logic        fu_op_saes64_ks1,
  output logic        fu_op_saes64_ks2,
  output logic        fu_op_saes64_imix,
  output logic        fu_op_saes64_encs,
  output logic        fu_op_saes64_encsm,
  output logic        fu_op_saes64_decs,
  output logic        fu_op_saes64_decsm,
  input  logic        fu_ready,
  input  logic [63:0] fu_rd,
  // response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rd,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // Registered FU request; op_oh bit i corresponds to cmd_op == i.
  typedef struct packed {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [3:0]  rcon;
    logic [6:0]  op_oh;
  } fu_req_t;

  typedef struct packed {
    logic [63:0] rd;
    logic [3:0]  tag;
    logic        err;
  } rsp_t;

  logic [1:0] state_q, state_d;
  fu_req_t    req_q;
  rsp_t       rsp_q;

  logic       cmd_fire;
  logic       cmd_illegal;
  logic [6:0] cmd_op_oh;
  logic       in_issue;
  logic       fu_done;
  logic       timeout_hit;

  assign in_issue    = (state_q == ST_ISSUE);
  assign cmd_ready   = (state_q == ST_IDLE);
  assign cmd_fire    = cmd_valid & cmd_ready;
  assign cmd_illegal = (cmd_op == OP_ILLEGAL);
  // fu_ready outside ISSUE is deliberately ignored.
  assign fu_done     = in_issue & fu_ready;

  always_comb begin
    cmd_op_oh = '0;
    case (cmd_op)
      3'd0:    cmd_op_oh = 7'b000_0001;
      3'd1:    cmd_op_oh = 7'b000_0010;
      3'd2:    cmd_op_oh = 7'b000_0100;
      3'd3:    cmd_op_oh = 7'b000_1000;
      3'd4:    cmd_op_oh = 7'b001_0000;
      3'd5:    cmd_op_oh = 7'b010_0000;
      3'd6:    cmd_op_oh = 7'b100_0000;
      default: cmd_op_oh = 7'b000_0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional ISSUE timeout
  // ---------------------------------------------------------------------------
`ifdef SAES64_ISSUE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;

  // Counts completed ISSUE cycles; cleared when ISSUE is entered so each
  // request gets the full budget.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      to_cnt_q <= '0;
    end else if (cmd_fire) begin
      to_cnt_q <= '0;
    end else if (in_issue && (to_cnt_q != TO_LAST)) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // fu_ready in the last counted cycle wins over the abort.
  assign timeout_hit = in_issue & ~fu_ready & (to_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) state_d = cmd_illegal ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (fu_done || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FU request register: loaded only for legal commands so an illegal op
  // leaves the FU-facing operands untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      req_q <= '0;
    end else if (cmd_fire && !cmd_illegal) begin
      req_q.rs1   <= cmd_rs1;
      req_q.rs2   <= cmd_rs2;
      req_q.rcon  <= cmd_rcon;
      req_q.op_oh <= cmd_op_oh;
    end
  end

  // ---------------------------------------------------------------------------
  // Response register. Tag is taken at accept; data/err are written only on
  // the transition into RESP, so the payload is frozen for all of RESP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rsp_q <= '0;
    end else begin
      if (cmd_fire) begin
        rsp_q.tag <= cmd_tag;
        if (cmd_illegal) begin
          rsp_q.rd  <= '0;
          rsp_q.err <= 1'b1;
        end
      end
      if (fu_done) begin
        rsp_q.rd  <= fu_rd;
        rsp_q.err <= 1'b0;
      end else if (timeout_hit) begin
        rsp_q.rd  <= '0;
        rsp_q.err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [6:0] fu_op_vis;

  // Op select is masked outside ISSUE so the FU never sees a stale op.
  assign fu_op_vis   = req_q.op_oh & {7{in_issue}};

  assign fu_valid    = in_issue;
  assign fu_rs1      = req_q.rs1;
  assign fu_rs2      = req_q.rs2;
  assign fu_enc_rcon = req_q.rcon;

  assign fu_op_saes64_ks1   = fu_op_vis[0];
  assign fu_op_saes64_ks2   = fu_op_vis[1];
  assign fu_op_saes64_imix  = fu_op_vis[2];
  assign fu_op_saes64_encs  = fu_op_vis[3];
  assign fu_op_saes64_encsm = fu_op_vis[4];
  assign fu_op_saes64_decs  = fu_op_vis[5];
  assign fu_op_saes64_decsm = fu_op_vis[6];

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rd    = rsp_q.rd;
  assign rsp_tag   = rsp_q.tag;
  assign rsp_err   = rsp_q.err;
  assign busy      = (state_q != ST_IDLE);

endmodule
